// File: rtl/endeavour_uart_pkg.sv
// endeavour_uart_pkg: shared state encoding, FIFO entry layout and frame width for the UART receive path
package endeavour_uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;
    typedef struct packed {
        logic                      frame_err;
        logic                      parity_err;
        logic [UART_DATA_BITS-1:0] data;
    } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive queue with sticky overflow flag
// Ports: clk/nreset (async active-low); push/push_entry write side (dropped when full and not popping);
//        head_valid/head_ready/head read side; overflow sticky, cleared by clear_overflow.
module uart_rx_fifo
    import endeavour_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      nreset,
    input  logic      push,
    input  rx_entry_t push_entry,
    output logic      head_valid,
    input  logic      head_ready,
    output rx_entry_t head,
    output logic      overflow,
    input  logic      clear_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    rx_entry_t      mem_q [FIFO_DEPTH];
    rx_entry_t      mem_d [FIFO_DEPTH];
    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic           overflow_q, overflow_d;
    logic           empty, full, pop, accept;
    always_comb begin
        empty      = wr_q == rd_q;
        full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop        = head_ready && !empty;
        // a pop frees the head slot in the same cycle, so a full FIFO can still take the push
        accept     = push && (!full || pop);
        mem_d      = mem_q;
        if (accept) mem_d[wr_q[AW-1:0]] = push_entry;
        wr_d       = wr_q + {{AW{1'b0}}, accept};
        rd_d       = rd_q + {{AW{1'b0}}, pop};
        overflow_d = (push && !accept) || (overflow_q && !clear_overflow);
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
        end
    end
    assign head_valid = !empty;
    assign head       = mem_q[rd_q[AW-1:0]];
    assign overflow   = overflow_q;
endmodule

// File: rtl/endeavour_uart_rx.sv
// endeavour_uart_rx: UART receiver (start, 8 data LSB first, optional parity, stop) feeding a small FIFO
// Ports: clk, nreset (async active-low); rx serial line; divisor = clocks per bit minus 1;
//        parity_en/parity_odd frame options; rx_valid/rx_ready/rx_data/rx_parity_err/rx_frame_err FIFO head;
//        overflow sticky drop flag with clear_overflow; busy = receiver not idle.
module endeavour_uart_rx
    import endeavour_uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 overflow,
    input  logic                 clear_overflow,
    output logic                 busy
);
    rx_state_e              state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d, div_q, div_d, div_in;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             data_q, data_d;
    logic                   pen_q, pen_d, podd_q, podd_d, perr_q, perr_d;
    logic                   rx_s, sample, push;
    rx_entry_t              entry, head;
    always_comb begin
        rx_s    = sync_q[1];
        sync_d  = {sync_q[0], rx};
        div_in  = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
        sample  = cnt_q == '0;
        cnt_d   = (state_q == IDLE) ? cnt_q : (sample ? div_q : cnt_q - DIV_WIDTH'(1));
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        perr_d  = perr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (!rx_s) begin
                // half-period preload puts every later sample near mid-bit
                state_d = START;
                div_d   = div_in;
                cnt_d   = div_in >> 1;
                pen_d   = parity_en;
                podd_d  = parity_odd;
                perr_d  = 1'b0;
            end
            START: if (sample) begin
                state_d = rx_s ? IDLE : DATA;
                idx_d   = 3'd0;
            end
            DATA: if (sample) begin
                data_d[idx_q] = rx_s;
                idx_d         = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = pen_q ? PARITY : STOP;
            end
            PARITY: if (sample) begin
                perr_d  = rx_s ^ (^data_q) ^ podd_q;
                state_d = STOP;
            end
            STOP: if (sample) begin
                push    = 1'b1;
                state_d = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        entry.frame_err  = ~rx_s;
        entry.parity_err = perr_q;
        entry.data       = data_q;
    end
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            perr_q  <= perr_d;
        end
    end
    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk            (clk),
        .nreset         (nreset),
        .push           (push),
        .push_entry     (entry),
        .head_valid     (rx_valid),
        .head_ready     (rx_ready),
        .head           (head),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );
    assign rx_data       = head.data;
    assign rx_parity_err = head.parity_err;
    assign rx_frame_err  = head.frame_err;
    assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_endeavour_uart_rx.sv
// tb_endeavour_uart_rx: directed frame vectors plus hand sequences for glitch, framing, overflow and reset cases
module tb_endeavour_uart_rx;
    logic        clk = 1'b0, nreset = 1'b1, rx = 1'b1;
    logic        parity_en = 1'b0, parity_odd = 1'b0, rx_ready = 1'b0, clear_overflow = 1'b0;
    logic [15:0] divisor = 16'd1;
    logic        rx_valid, rx_parity_err, rx_frame_err, overflow, busy;
    logic [7:0]  rx_data;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    endeavour_uart_rx #(.DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .nreset(nreset), .rx(rx), .divisor(divisor),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .overflow(overflow), .clear_overflow(clear_overflow), .busy(busy)
    );
    typedef struct {
        logic [7:0]  d;
        logic [15:0] div;
        int          bc;
        logic        pen, podd, pinv;
        logic [7:0]  exp_data;
        logic        exp_perr;
    } vec_t;
    vec_t vecs [6];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic send_frame(input logic [7:0] d, input int bc, input logic pen, input logic pbit, input logic stop);
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(d[i], bc);
        if (pen) hold(pbit, bc);
        hold(stop, bc);
    endtask
    task automatic wait_valid(input string name);
        int n = 0;
        while (!rx_valid && n < 300) begin @(posedge clk); #1; n++; end
        check({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
    endtask
    task automatic pop();
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask
    task automatic check_zero_outputs(input string tag);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_perr"}, {31'd0, rx_parity_err}, 32'd0);
        check({tag, "_ferr"}, {31'd0, rx_frame_err}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic saw_busy, saw_valid;
        vecs[0] = '{8'hA5, 16'd1,  2,  1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 16'd1,  2,  1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[2] = '{8'h07, 16'd1,  2,  1'b1, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[3] = '{8'h81, 16'd3,  4,  1'b0, 1'b0, 1'b0, 8'h81, 1'b0};
        vecs[4] = '{8'h5A, 16'd0,  2,  1'b1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vecs[5] = '{8'hC3, 16'd15, 16, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1};
        #2 nreset = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        hold(1'b1, 4);
        for (int i = 0; i < 6; i++) begin
            divisor    = vecs[i].div;
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            hold(1'b1, 4);
            send_frame(vecs[i].d, vecs[i].bc, vecs[i].pen, (^vecs[i].d) ^ vecs[i].podd ^ vecs[i].pinv, 1'b1);
            wait_valid($sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_perr", i), {31'd0, rx_parity_err}, {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d_ferr", i), {31'd0, rx_frame_err}, 32'd0);
            pop();
            hold(1'b1, 2);
            check($sformatf("vec%0d_drained", i), {31'd0, rx_valid}, 32'd0);
        end
        divisor = 16'd15;
        parity_en = 1'b0;
        hold(1'b1, 4);
        saw_busy = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rx = (i < 3) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            saw_busy  |= busy;
            saw_valid |= rx_valid;
        end
        check("glitch_busy_pulse", {31'd0, saw_busy}, 32'd1);
        check("glitch_no_valid", {31'd0, saw_valid}, 32'd0);
        check("glitch_idle_again", {31'd0, busy}, 32'd0);
        divisor = 16'd5;
        hold(1'b1, 4);
        send_frame(8'h33, 6, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 4);
        hold(1'b1, 12);
        send_frame(8'h5A, 6, 1'b0, 1'b0, 1'b1);
        wait_valid("ferr_first");
        check("ferr_first_data", {24'd0, rx_data}, 32'h33);
        check("ferr_first_ferr", {31'd0, rx_frame_err}, 32'd1);
        check("ferr_first_perr", {31'd0, rx_parity_err}, 32'd0);
        pop();
        wait_valid("ferr_next");
        check("ferr_next_data", {24'd0, rx_data}, 32'h5A);
        check("ferr_next_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("ferr_next_perr", {31'd0, rx_parity_err}, 32'd0);
        pop();
        hold(1'b1, 4);
        check("ferr_no_spurious", {31'd0, rx_valid}, 32'd0);
        divisor = 16'd1;
        hold(1'b1, 4);
        check("ovf_initial", {31'd0, overflow}, 32'd0);
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 2, 1'b0, 1'b0, 1'b1);
        hold(1'b1, 10);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            wait_valid($sformatf("ovf_pop%0d", k));
            check($sformatf("ovf_pop%0d_data", k), {24'd0, rx_data}, k);
            pop();
        end
        hold(1'b1, 2);
        check("ovf_drained", {31'd0, rx_valid}, 32'd0);
        check("ovf_still_set", {31'd0, overflow}, 32'd1);
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        hold(1'b1, 4);
        hold(1'b0, 2);
        hold(1'b1, 6);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        nreset = 1'b0;
        rx = 1'b1;
        #2 check_zero_outputs("midrst");
        @(posedge clk); #1;
        nreset = 1'b1;
        hold(1'b1, 4);
        send_frame(8'h81, 2, 1'b0, 1'b0, 1'b1);
        wait_valid("midrst_rx");
        check("midrst_data", {24'd0, rx_data}, 32'h81);
        check("midrst_ferr", {31'd0, rx_frame_err}, 32'd0);
        pop();
        hold(1'b1, 30);
        check("midrst_only_one", {31'd0, rx_valid}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
